sdp_ram: RTL and testbench

// - Simple dual-port RAM: one write port, one read port, single clock domain.
// - Storage primitive under shift_reg and other delay/buffer blocks.
// - Written to infer block RAM. Read and write ports may be enabled in the same cycle.

---
 rtl/sdp_ram.sv | 67 ++++++
 tb/tb_sdp_ram.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port, one clock domain.
// Latency: 1 cycle read (OUT_REG=0) or 2 cycles (OUT_REG=1); writes commit at the posedge.
// Backpressure: none; both ports accept an operation every cycle with no stall.
module sdp_ram #(
  parameter int WIDTH   = 25,
  parameter int SIZE    = 512,
  parameter bit OUT_REG = 1'b0,
  parameter int AW      = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rden,
  input  logic [AW-1:0]    rdaddr,
  output logic [WIDTH-1:0] rddata,
  input  logic             wren,
  input  logic [AW-1:0]    wraddr,
  input  logic [WIDTH-1:0] wrdata
);

  // One extra bit so SIZE itself is representable when SIZE is a power of two.
  localparam logic [AW:0] SIZE_W = (AW+1)'(SIZE);

  logic [WIDTH-1:0] mem [SIZE];
  logic [WIDTH-1:0] rd_q;
  logic             rd_in_range;
  logic             wr_in_range;

  // Addresses past the last word only exist when SIZE is not a power of two.
  assign rd_in_range = {1'b0, rdaddr} < SIZE_W;
  assign wr_in_range = {1'b0, wraddr} < SIZE_W;

  // Write port; the array carries no reset so writes commit even while rst_n is low.
  always_ff @(posedge clk) begin
    if (wren && wr_in_range) begin
      mem[wraddr] <= wrdata;
    end
  end

  // Read stage: samples the array before this edge's write lands, giving read-first collisions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else if (rden) begin
      rd_q <= rd_in_range ? mem[rdaddr] : '0;
    end
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic [WIDTH-1:0] out_q;

      // Output pipeline stage, free-running so it always trails the read stage by one cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_q <= '0;
        end else begin
          out_q <= rd_q;
        end
      end

      assign rddata = out_q;
    end else begin : g_no_out_reg
      assign rddata = rd_q;
    end
  endgenerate

endmodule

// File: tb/tb_sdp_ram.sv
// Bench for sdp_ram: a 512x25 latency-1 instance and a 10-word latency-2 instance.
// Directed steps from the block's documented behaviour, then randomized traffic
// against an array-based reference model of both instances.
module tb_sdp_ram;

  logic        clk;
  logic        rst_n;

  logic        a_rden, a_wren;
  logic [8:0]  a_rdaddr, a_wraddr;
  logic [24:0] a_wrdata, a_rddata;

  logic        b_rden, b_wren;
  logic [3:0]  b_rdaddr, b_wraddr;
  logic [24:0] b_wrdata, b_rddata;

  int checks;
  int failures;

  // Reference state: word arrays plus the value each output is expected to show.
  logic [24:0] mem_a [512];
  logic [24:0] mem_b [10];
  logic [24:0] exp_a;
  logic [24:0] exp_b;
  logic [24:0] s1_b;

  sdp_ram #(.WIDTH(25), .SIZE(512), .OUT_REG(1'b0)) u_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .rden   (a_rden),
    .rdaddr (a_rdaddr),
    .rddata (a_rddata),
    .wren   (a_wren),
    .wraddr (a_wraddr),
    .wrdata (a_wrdata)
  );

  sdp_ram #(.WIDTH(25), .SIZE(10), .OUT_REG(1'b1)) u_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .rden   (b_rden),
    .rdaddr (b_rdaddr),
    .rddata (b_rddata),
    .wren   (b_wren),
    .wraddr (b_wraddr),
    .wrdata (b_wrdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // One clock: the model reads what the RAM held before the edge, then applies the write.
  task automatic step_all();
    @(posedge clk);
    if (rst_n) begin
      if (a_rden) exp_a = mem_a[a_rdaddr];
      exp_b = s1_b;
      if (b_rden) s1_b = (int'(b_rdaddr) < 10) ? mem_b[b_rdaddr] : 25'd0;
    end
    if (a_wren) mem_a[a_wraddr] = a_wrdata;
    if (b_wren && int'(b_wraddr) < 10) mem_b[b_wraddr] = b_wrdata;
    #1;
  endtask

  task automatic idle_all();
    a_rden = 1'b0; a_wren = 1'b0;
    b_rden = 1'b0; b_wren = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 512; i++) mem_a[i] = '0;
    for (int i = 0; i < 10; i++) mem_b[i] = '0;
    exp_a = '0; exp_b = '0; s1_b = '0;
    a_rdaddr = '0; a_wraddr = '0; a_wrdata = '0;
    b_rdaddr = '0; b_wraddr = '0; b_wrdata = '0;
    idle_all();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // Reset state of both instances.
    step_all();
    step_all();
    chk("reset_a", 32'(a_rddata), 32'h0);
    chk("reset_b", 32'(b_rddata), 32'h0);
    rst_n = 1'b1;

    // Load 0x1ABCDEF onto the output, then drop reset mid-cycle.
    a_wren = 1'b1; a_wraddr = 9'd0; a_wrdata = 25'h1ABCDEF;
    step_all();
    a_wren = 1'b0; a_rden = 1'b1; a_rdaddr = 9'd0;
    step_all();
    a_rden = 1'b0;
    chk("pre_reset_val", 32'(a_rddata), 32'h1ABCDEF);
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset", 32'(a_rddata), 32'h0);
    exp_a = '0; exp_b = '0; s1_b = '0;

    // A write while in reset still commits; the output stays cleared.
    a_wren = 1'b1; a_wraddr = 9'd20; a_wrdata = 25'h0155AA;
    step_all();
    chk("reset_hold", 32'(a_rddata), 32'h0);
    rst_n = 1'b1;
    a_wren = 1'b0; a_rden = 1'b1; a_rdaddr = 9'd20;
    step_all();
    a_rden = 1'b0;
    chk("write_in_reset", 32'(a_rddata), 32'h0155AA);

    // Basic write, read, and hold.
    a_wren = 1'b1; a_wraddr = 9'd3; a_wrdata = 25'h5;
    step_all();
    a_wren = 1'b0; a_rden = 1'b1; a_rdaddr = 9'd3;
    step_all();
    chk("read3", 32'(a_rddata), 32'h5);
    a_rden = 1'b0; a_rdaddr = 9'd20;
    step_all();
    chk("hold1", 32'(a_rddata), 32'h5);
    step_all();
    chk("hold2", 32'(a_rddata), 32'h5);

    // Same-address collision returns the old word.
    a_wren = 1'b1; a_wraddr = 9'd7; a_wrdata = 25'h11;
    step_all();
    a_rden = 1'b1; a_rdaddr = 9'd7; a_wrdata = 25'h22;
    step_all();
    chk("collide_old", 32'(a_rddata), 32'h11);
    a_wren = 1'b0;
    step_all();
    chk("collide_new", 32'(a_rddata), 32'h22);
    a_rden = 1'b0;

    // Out-of-range handling on the 10-word latency-2 instance.
    b_wren = 1'b1; b_wraddr = 4'd2; b_wrdata = 25'h22222;
    step_all();
    b_wraddr = 4'd4; b_wrdata = 25'h44444;
    step_all();
    b_wraddr = 4'd9; b_wrdata = 25'h1234567;
    step_all();
    b_wraddr = 4'd12; b_wrdata = 25'h0AAAAAA;
    step_all();
    b_wren = 1'b0; b_rden = 1'b1; b_rdaddr = 4'd9;
    step_all();
    b_rden = 1'b0;
    chk("b_lat_not_yet", 32'(b_rddata), 32'h0);
    step_all();
    chk("b_read9_lat2", 32'(b_rddata), 32'h1234567);
    b_rden = 1'b1; b_rdaddr = 4'd12;
    step_all();
    b_rden = 1'b0;
    chk("b_oor_lat_not_yet", 32'(b_rddata), 32'h1234567);
    step_all();
    chk("b_read12_zero", 32'(b_rddata), 32'h0);
    b_rden = 1'b1; b_rdaddr = 4'd2;
    step_all();
    b_rdaddr = 4'd4;
    step_all();
    chk("b_no_alias2", 32'(b_rddata), 32'h22222);
    b_rden = 1'b0;
    step_all();
    chk("b_no_alias4", 32'(b_rddata), 32'h44444);

    // Full sweep: write i everywhere, then read back-to-back.
    a_wren = 1'b1;
    for (int i = 0; i < 512; i++) begin
      a_wraddr = 9'(i); a_wrdata = 25'(i);
      step_all();
    end
    a_wren = 1'b0; a_rden = 1'b1;
    for (int i = 0; i < 512; i++) begin
      a_rdaddr = 9'(i);
      step_all();
      chk("sweep", 32'(a_rddata), 32'(i));
    end

    // Delay line: write k, read k+1, counting data.
    a_wren = 1'b1; a_rden = 1'b1;
    for (int n = 0; n < 1100; n++) begin
      a_wraddr = 9'(n % 512);
      a_rdaddr = 9'((n + 1) % 512);
      a_wrdata = 25'(n);
      step_all();
      if (n >= 511) chk("delay_line", 32'(a_rddata), 32'(n - 511));
    end
    idle_all();

    // Randomized traffic on both instances against the reference model.
    for (int n = 0; n < 600; n++) begin
      a_rden   = 1'($urandom_range(0, 1));
      a_wren   = 1'($urandom_range(0, 1));
      a_rdaddr = ($urandom_range(0, 1) == 1) ? 9'($urandom_range(0, 15)) : 9'($urandom);
      a_wraddr = ($urandom_range(0, 1) == 1) ? 9'($urandom_range(0, 15)) : 9'($urandom);
      a_wrdata = 25'($urandom);
      b_rden   = 1'($urandom_range(0, 1));
      b_wren   = 1'($urandom_range(0, 1));
      b_rdaddr = 4'($urandom_range(0, 15));
      b_wraddr = 4'($urandom_range(0, 15));
      b_wrdata = 25'($urandom);
      step_all();
      chk("rand_a", 32'(a_rddata), 32'(exp_a));
      chk("rand_b", 32'(b_rddata), 32'(exp_b));
    end
    idle_all();
    step_all();
    chk("rand_a_tail", 32'(a_rddata), 32'(exp_a));
    chk("rand_b_tail", 32'(b_rddata), 32'(exp_b));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
